// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core: data width, memory-op encoding,
// commit-stage state encoding and architectural reset values.
package core_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  localparam logic [DATA_WIDTH-1:0] RESET_PC = 16'h0000;
  localparam logic [DATA_WIDTH-1:0] RESET_SP = 16'hFFFE;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_e;

  typedef enum logic [1:0] {
    StReady     = 2'b00,
    StMemWait   = 2'b01,
    StWriteback = 2'b10
  } state_e;

endpackage

// File: rtl/gpr_file.sv
// Eight general registers with three combinational read ports and one write port;
// r0 is hardwired to zero.
module gpr_file #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [2:0]            i_rs0_addr,
  input  logic [2:0]            i_rs1_addr,
  input  logic [2:0]            i_rs2_addr,
  output logic [DATA_WIDTH-1:0] o_rs0_data,
  output logic [DATA_WIDTH-1:0] o_rs1_data,
  output logic [DATA_WIDTH-1:0] o_rs2_data,
  input  logic                  i_we,
  input  logic [2:0]            i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data
);

  logic [DATA_WIDTH-1:0] r_regs [8];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_wr_addr != 3'd0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Reads see pre-edge contents, so a same-cycle write is not forwarded.
  assign o_rs0_data = (i_rs0_addr == 3'd0) ? '0 : r_regs[i_rs0_addr];
  assign o_rs1_data = (i_rs1_addr == 3'd0) ? '0 : r_regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 3'd0) ? '0 : r_regs[i_rs2_addr];

endmodule

// File: rtl/state_commit_unit.sv
// Architectural state (PC/SP/RA/GPRs) plus data-memory handshake sequencing;
// commits datapath next-state values once per accepted instruction.
module state_commit_unit #(
  parameter int unsigned                 DATA_WIDTH = core_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]       RESET_PC   = core_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0]       RESET_SP   = core_pkg::RESET_SP
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_inst_valid,
  output logic                  o_inst_ready,
  input  logic [1:0]            i_mem_op,
  input  logic [2:0]            i_rd_addr,
  input  logic [2:0]            i_rs0_addr,
  input  logic [2:0]            i_rs1_addr,
  input  logic [2:0]            i_rs2_addr,
  input  logic                  i_reg_we,
  input  logic                  i_sp_we,
  input  logic                  i_ra_we,
  output logic [DATA_WIDTH-1:0] o_rs0_data,
  output logic [DATA_WIDTH-1:0] o_rs1_data,
  output logic [DATA_WIDTH-1:0] o_rs2_data,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_sp,
  output logic [DATA_WIDTH-1:0] o_ra,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic [DATA_WIDTH-1:0] i_pc_next,
  input  logic [DATA_WIDTH-1:0] i_sp_next,
  input  logic [DATA_WIDTH-1:0] i_ra_next,
  input  logic [DATA_WIDTH-1:0] i_mem_addr_in,
  input  logic [DATA_WIDTH-1:0] i_mem_wdata_in,
  output logic [DATA_WIDTH-1:0] o_memory_in,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_instret
);

  import core_pkg::*;

  state_e                r_state;
  state_e                w_state_next;
  logic                  w_accept_mem;
  logic                  w_capture;
  logic                  w_commit;
  logic                  w_is_mem;

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_sp;
  logic [DATA_WIDTH-1:0] r_ra;
  logic [DATA_WIDTH-1:0] r_instret;
  logic [DATA_WIDTH-1:0] r_load_buf;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  // mem_op 11 is undefined and falls through as a non-memory instruction.
  assign w_is_mem = (i_mem_op == MEM_LOAD) || (i_mem_op == MEM_STORE);

  always_comb begin
    w_state_next = r_state;
    o_inst_ready = 1'b0;
    w_accept_mem = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      StReady: begin
        if (i_inst_valid) begin
          if (w_is_mem) begin
            w_accept_mem = 1'b1;
            w_state_next = StMemWait;
          end else begin
            o_inst_ready = 1'b1;
          end
        end
      end
      StMemWait: begin
        if (i_mem_ack) begin
          w_capture    = 1'b1;
          w_state_next = StWriteback;
        end
      end
      StWriteback: begin
        o_inst_ready = 1'b1;
        w_state_next = StReady;
      end
      default: w_state_next = StReady;
    endcase
  end

  assign w_commit = o_inst_ready && i_inst_valid;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StReady;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_load_buf  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_mem_req <= (w_state_next == StMemWait);
      if (w_accept_mem) begin
        r_mem_we    <= (i_mem_op == MEM_STORE);
        r_mem_addr  <= i_mem_addr_in;
        r_mem_wdata <= i_mem_wdata_in;
      end
      if (w_capture) begin
        r_load_buf <= i_mem_rdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc      <= RESET_PC;
      r_sp      <= RESET_SP;
      r_ra      <= '0;
      r_instret <= '0;
    end else if (w_commit) begin
      r_pc      <= i_pc_next;
      r_instret <= r_instret + 1'b1;
      if (i_sp_we) r_sp <= i_sp_next;
      if (i_ra_we) r_ra <= i_ra_next;
    end
  end

  gpr_file #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gpr_file (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_rs0_addr (i_rs0_addr),
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .o_rs0_data (o_rs0_data),
    .o_rs1_data (o_rs1_data),
    .o_rs2_data (o_rs2_data),
    .i_we       (w_commit && i_reg_we),
    .i_wr_addr  (i_rd_addr),
    .i_wr_data  (i_result)
  );

  assign o_pc        = r_pc;
  assign o_sp        = r_sp;
  assign o_ra        = r_ra;
  assign o_instret   = r_instret;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_memory_in = (r_state == StWriteback) ? r_load_buf : '0;

endmodule

// File: tb/tb_state_commit_unit.sv
// Directed bench for state_commit_unit: reset, ALU/load/store commits, r0, instret wrap
// and reset during an outstanding memory request.
module tb_state_commit_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  mem_op;
  logic [2:0]  rd_addr, rs0_addr, rs1_addr, rs2_addr;
  logic        reg_we, sp_we, ra_we;
  logic [15:0] rs0_data, rs1_data, rs2_data;
  logic [15:0] pc, sp, ra;
  logic [15:0] result, pc_next, sp_next, ra_next;
  logic [15:0] mem_addr_in, mem_wdata_in;
  logic [15:0] memory_in;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instret;

  int errors = 0;
  int checks = 0;
  int exp_instret = 0;

  always #5 clk = ~clk;

  state_commit_unit dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_inst_valid   (inst_valid),
    .o_inst_ready   (inst_ready),
    .i_mem_op       (mem_op),
    .i_rd_addr      (rd_addr),
    .i_rs0_addr     (rs0_addr),
    .i_rs1_addr     (rs1_addr),
    .i_rs2_addr     (rs2_addr),
    .i_reg_we       (reg_we),
    .i_sp_we        (sp_we),
    .i_ra_we        (ra_we),
    .o_rs0_data     (rs0_data),
    .o_rs1_data     (rs1_data),
    .o_rs2_data     (rs2_data),
    .o_pc           (pc),
    .o_sp           (sp),
    .o_ra           (ra),
    .i_result       (result),
    .i_pc_next      (pc_next),
    .i_sp_next      (sp_next),
    .i_ra_next      (ra_next),
    .i_mem_addr_in  (mem_addr_in),
    .i_mem_wdata_in (mem_wdata_in),
    .o_memory_in    (memory_in),
    .o_mem_req      (mem_req),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_ack      (mem_ack),
    .i_mem_rdata    (mem_rdata),
    .o_instret      (instret)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_valid = 0; mem_op = 2'b00; rd_addr = 0;
    rs0_addr = 0; rs1_addr = 0; rs2_addr = 0;
    reg_we = 0; sp_we = 0; ra_we = 0;
    result = 0; pc_next = 0; sp_next = 0; ra_next = 0;
    mem_addr_in = 0; mem_wdata_in = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #12;
    reset_n = 1;
    rs0_addr = 3'd1; rs1_addr = 3'd4; rs2_addr = 3'd7;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc cyc%0d got %h want 0000", c, pc); end
      checks++;
      if (sp !== 16'hFFFE) begin errors++; $display("FAIL reset_sp cyc%0d got %h want fffe", c, sp); end
      checks++;
      if (ra !== 16'h0000) begin errors++; $display("FAIL reset_ra cyc%0d got %h want 0000", c, ra); end
      checks++;
      if ({rs0_data, rs1_data, rs2_data} !== 48'h0) begin
        errors++; $display("FAIL reset_rs cyc%0d got %h %h %h want 0", c, rs0_data, rs1_data, rs2_data);
      end
      checks++;
      if (mem_req !== 1'b0 || instret !== 16'h0000 || inst_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctl cyc%0d req=%b instret=%h rdy=%b want 0 0000 0", c, mem_req, instret, inst_ready);
      end
    end
  endtask

  task automatic test_alu();
    inst_valid = 1; reg_we = 1; rd_addr = 3'd3; result = 16'h1234; pc_next = 16'h0002;
    rs0_addr = 3'd3;
    #1;
    checks++;
    if (inst_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b want 1", inst_ready); end
    checks++;
    if (rs0_data !== 16'h0000) begin errors++; $display("FAIL alu_old_read got %h want 0000", rs0_data); end
    step();
    exp_instret++;
    inst_valid = 0; reg_we = 0;
    checks++;
    if (rs0_data !== 16'h1234) begin errors++; $display("FAIL alu_r3 got %h want 1234", rs0_data); end
    checks++;
    if (pc !== 16'h0002) begin errors++; $display("FAIL alu_pc got %h want 0002", pc); end
    checks++;
    if (instret !== 16'(exp_instret)) begin errors++; $display("FAIL alu_instret got %h want %h", instret, 16'(exp_instret)); end
  endtask

  task automatic test_load();
    inst_valid = 1; mem_op = 2'b01; reg_we = 1; rd_addr = 3'd5;
    mem_addr_in = 16'h4000; pc_next = 16'h0004; rs1_addr = 3'd5;
    #1;
    checks++;
    if (inst_ready !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL load_accept rdy=%b req=%b want 0 0", inst_ready, mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h4000 || mem_we !== 1'b0 || inst_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_wait1 req=%b addr=%h we=%b rdy=%b want 1 4000 0 0", mem_req, mem_addr, mem_we, inst_ready);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h4000) begin
      errors++; $display("FAIL load_wait2 req=%b addr=%h want 1 4000", mem_req, mem_addr);
    end
    mem_ack = 1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 0; mem_rdata = 16'h0000;
    checks++;
    if (mem_req !== 1'b0 || inst_ready !== 1'b1 || memory_in !== 16'hBEEF) begin
      errors++;
      $display("FAIL load_wb req=%b rdy=%b mem_in=%h want 0 1 beef", mem_req, inst_ready, memory_in);
    end
    checks++;
    if (rs1_data !== 16'h0000) begin errors++; $display("FAIL load_r5_early got %h want 0000", rs1_data); end
    result = memory_in;
    step();
    exp_instret++;
    inst_valid = 0; reg_we = 0; mem_op = 2'b00;
    checks++;
    if (rs1_data !== 16'hBEEF || pc !== 16'h0004) begin
      errors++; $display("FAIL load_commit r5=%h pc=%h want beef 0004", rs1_data, pc);
    end
    checks++;
    if (memory_in !== 16'h0000 || instret !== 16'(exp_instret)) begin
      errors++; $display("FAIL load_after mem_in=%h instret=%h want 0000 %h", memory_in, instret, 16'(exp_instret));
    end
  endtask

  task automatic test_store();
    inst_valid = 1; mem_op = 2'b10; sp_we = 1; sp_next = 16'hFFFC; reg_we = 0;
    rd_addr = 3'd6; result = 16'h1111; mem_addr_in = 16'hFFFE; mem_wdata_in = 16'hA5A5;
    pc_next = 16'h0006; rs2_addr = 3'd6;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'hA5A5 || mem_addr !== 16'hFFFE) begin
      errors++;
      $display("FAIL store_req req=%b we=%b wdata=%h addr=%h want 1 1 a5a5 fffe", mem_req, mem_we, mem_wdata, mem_addr);
    end
    mem_ack = 1;
    step();
    mem_ack = 0;
    checks++;
    if (sp !== 16'hFFFE || inst_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL store_wb sp=%h rdy=%b req=%b want fffe 1 0", sp, inst_ready, mem_req);
    end
    step();
    exp_instret++;
    inst_valid = 0; sp_we = 0; mem_op = 2'b00;
    checks++;
    if (sp !== 16'hFFFC || rs2_data !== 16'h0000 || pc !== 16'h0006) begin
      errors++; $display("FAIL store_commit sp=%h r6=%h pc=%h want fffc 0000 0006", sp, rs2_data, pc);
    end
  endtask

  task automatic test_r0_and_op11();
    inst_valid = 1; mem_op = 2'b11; reg_we = 1; rd_addr = 3'd0; result = 16'hFFFF;
    ra_we = 1; ra_next = 16'h00AA; pc_next = 16'h0008; rs0_addr = 3'd0;
    #1;
    checks++;
    if (inst_ready !== 1'b1) begin errors++; $display("FAIL op11_ready got %b want 1", inst_ready); end
    step();
    exp_instret++;
    inst_valid = 0; reg_we = 0; ra_we = 0; mem_op = 2'b00;
    checks++;
    if (rs0_data !== 16'h0000 || mem_req !== 1'b0) begin
      errors++; $display("FAIL r0_write r0=%h req=%b want 0000 0", rs0_data, mem_req);
    end
    checks++;
    if (ra !== 16'h00AA) begin errors++; $display("FAIL ra_commit got %h want 00aa", ra); end
  endtask

  task automatic test_instret_wrap();
    inst_valid = 1; pc_next = 16'h0010;
    while (exp_instret < 16'hFFFF) begin
      step();
      exp_instret++;
    end
    checks++;
    if (instret !== 16'hFFFF) begin errors++; $display("FAIL instret_max got %h want ffff", instret); end
    step();
    inst_valid = 0;
    exp_instret = 0;
    checks++;
    if (instret !== 16'h0000) begin errors++; $display("FAIL instret_wrap got %h want 0000", instret); end
  endtask

  task automatic test_reset_midflight();
    inst_valid = 1; mem_op = 2'b01; reg_we = 1; rd_addr = 3'd3;
    mem_addr_in = 16'h2222; pc_next = 16'h0040; rs0_addr = 3'd3;
    step();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req got %b want 1", mem_req); end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 16'h0000 || pc !== 16'h0000 || rs0_data !== 16'h0000) begin
      errors++;
      $display("FAIL mid_async req=%b addr=%h pc=%h r3=%h want 0 0000 0000 0000", mem_req, mem_addr, pc, rs0_data);
    end
    inst_valid = 0; reg_we = 0; mem_op = 2'b00;
    step();
    reset_n = 1;
    step();
    mem_ack = 1; mem_rdata = 16'h7777;
    step();
    mem_ack = 0; mem_rdata = 0;
    step();
    checks++;
    if (mem_req !== 1'b0 || memory_in !== 16'h0000 || instret !== 16'h0000 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL mid_stray req=%b mem_in=%h instret=%h pc=%h want 0 0000 0000 0000",
               mem_req, memory_in, instret, pc);
    end
    inst_valid = 1;
    #1;
    checks++;
    if (inst_ready !== 1'b1 || rs0_data !== 16'h0000) begin
      errors++; $display("FAIL mid_ready rdy=%b r3=%h want 1 0000", inst_ready, rs0_data);
    end
    inst_valid = 0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_r0_and_op11();
    test_instret_wrap();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
